// File: rtl/song_pkg.sv
// -----------------------------------------------------------------------------
// song_pkg
// Shared definitions for the song sequencer:
//   - ROM word field positions (12-bit word: adv flag, field_a, field_b)
//   - sequencer state encoding
//   - default sizes for voices, songs and entries
//   - a helper that splits a ROM word into its fields
// No ports; imported by song_reader and voice_alloc.
// -----------------------------------------------------------------------------
package song_pkg;

    // Default sizing of the sequencer
    localparam int DEF_NUM_VOICES = 3;
    localparam int DEF_ENTRY_BITS = 5;
    localparam int DEF_SONG_BITS  = 2;

    // Data widths
    localparam int ROM_W  = 12;
    localparam int NOTE_W = 6;
    localparam int ADDR_W = DEF_SONG_BITS + DEF_ENTRY_BITS;

    // ROM word field positions
    localparam int ADV_BIT  = 11;
    localparam int NOTE_MSB = 10;
    localparam int NOTE_LSB = 5;
    localparam int DUR_MSB  = 4;
    localparam int DUR_LSB  = 0;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_PAUSED  = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_ADVANCE = 3'd4
    } state_e;

    // One decoded ROM entry. field_a is the note number or the advance
    // count; field_b is the duration, zero-extended to the note width.
    typedef struct packed {
        logic              adv;
        logic [NOTE_W-1:0] field_a;
        logic [NOTE_W-1:0] field_b;
    } rom_entry_t;

    function automatic rom_entry_t unpack_word(input logic [ROM_W-1:0] word);
        rom_entry_t e;
        e.adv     = word[ADV_BIT];
        e.field_a = word[NOTE_MSB:NOTE_LSB];
        e.field_b = NOTE_W'(word[DUR_MSB:DUR_LSB]);
        return e;
    endfunction

    // True when a note entry carries nothing to play
    function automatic logic is_noop(input rom_entry_t e);
        return (e.field_a == '0) || (e.field_b == '0);
    endfunction

endpackage : song_pkg

// File: rtl/song_reader_voice_alloc.sv
// -----------------------------------------------------------------------------
// voice_alloc
// Combinational lowest-index-first allocator over the note players' busy
// flags.
// Ports:
//   voice_busy_i  in   NUM_VOICES  per-voice busy flag (1 = playing)
//   free_idx_o    out  VOICE_W     lowest index whose busy flag is clear
//   any_free_o    out  1           at least one voice is free
// free_idx_o is 0 when no voice is free; qualify it with any_free_o.
// -----------------------------------------------------------------------------
module voice_alloc
    import song_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int VOICE_W    = 2
) (
    input  logic [NUM_VOICES-1:0] voice_busy_i,
    output logic [VOICE_W-1:0]    free_idx_o,
    output logic                  any_free_o
);

    // Scan from the top down so the last hit, the lowest free index, wins.
    always_comb begin
        // NOTE: every output gets a default first so this block can never
        // infer a latch, whatever the busy pattern.
        free_idx_o = '0;
        any_free_o = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!voice_busy_i[i]) begin
                free_idx_o = VOICE_W'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule : voice_alloc

// File: rtl/song_reader.sv
// -----------------------------------------------------------------------------
// song_reader
// Walks the 2^ENTRY_BITS entries of one song held in an external registered
// ROM. Note entries are dispatched to the lowest free note player; advance
// entries hold the sequencer for a number of beat ticks.
// Ports:
//   clk         in   1           system clock
//   reset       in   1           asynchronous, active-high reset
//   play        in   1           level: 1 = run, 0 = pause
//   new_song    in   1           pulse: load song_sel, restart at entry 0
//   song_sel    in   SONG_BITS   song index, sampled on new_song
//   beat        in   1           one-cycle beat tick
//   voice_busy  in   NUM_VOICES  busy flag per note player
//   rom_addr    out  SONG+ENTRY  {song, entry} to the song ROM
//   rom_dout    in   12          ROM data, valid one cycle after rom_addr
//   new_note    out  1           one-cycle load pulse to note player 'voice'
//   voice       out  VOICE_W     target voice index
//   note        out  6           note number
//   duration    out  6           duration in beats
//   song_done   out  1           one-cycle pulse after the last entry
// All outputs come straight from registers.
// Per-entry timing: FETCH (ROM samples the address), DECODE (data valid),
// then ADVANCE; back-to-back note entries are three cycles apart.
// -----------------------------------------------------------------------------
module song_reader
    import song_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int ENTRY_BITS = DEF_ENTRY_BITS,
    parameter int SONG_BITS  = DEF_SONG_BITS,
    localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            play,
    input  logic                            new_song,
    input  logic [SONG_BITS-1:0]            song_sel,
    input  logic                            beat,
    input  logic [NUM_VOICES-1:0]           voice_busy,
    output logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr,
    input  logic [ROM_W-1:0]                rom_dout,
    output logic                            new_note,
    output logic [VOICE_W-1:0]              voice,
    output logic [NOTE_W-1:0]               note,
    output logic [NOTE_W-1:0]               duration,
    output logic                            song_done
);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_e                  state_q;
    logic [SONG_BITS-1:0]    song_q;
    logic [ENTRY_BITS-1:0]   entry_q;
    logic [NOTE_W-1:0]       wait_cnt_q;
    logic                    new_note_q;
    logic                    song_done_q;
    logic [VOICE_W-1:0]      voice_q;
    logic [NOTE_W-1:0]       note_q;
    logic [NOTE_W-1:0]       duration_q;

    // -------------------------------------------------------------------------
    // ROM word decode and voice allocation
    // -------------------------------------------------------------------------
    rom_entry_t         cur_entry;
    logic [VOICE_W-1:0] free_idx;
    logic               any_free;

    assign cur_entry = unpack_word(rom_dout);

    voice_alloc #(
        .NUM_VOICES (NUM_VOICES),
        .VOICE_W    (VOICE_W)
    ) u_voice_alloc (
        .voice_busy_i (voice_busy),
        .free_idx_o   (free_idx),
        .any_free_o   (any_free)
    );

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PAUSED;
            song_q      <= '0;
            entry_q     <= '0;
            wait_cnt_q  <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
            voice_q     <= '0;
            note_q      <= '0;
            duration_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every decision
            // below sees the register values from before this edge and the
            // two pulse defaults can be overridden later in the block.
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;

            if (new_song) begin
                // Song change overrides whatever the current state wanted,
                // including a beat or an ADVANCE in the same cycle.
                song_q     <= song_sel;
                entry_q    <= '0;
                wait_cnt_q <= '0;
                state_q    <= ST_PAUSED;
            end else begin
                unique case (state_q)
                    ST_PAUSED: begin
                        if (play) state_q <= ST_FETCH;
                    end

                    // The ROM samples rom_addr on this edge.
                    ST_FETCH: begin
                        state_q <= ST_DECODE;
                    end

                    ST_DECODE: begin
                        if (cur_entry.adv) begin
                            wait_cnt_q <= cur_entry.field_a;
                            state_q    <= (cur_entry.field_a == '0) ? ST_ADVANCE : ST_WAIT;
                        end else if (is_noop(cur_entry)) begin
                            state_q <= ST_ADVANCE;
                        end else if (play && any_free) begin
                            new_note_q <= 1'b1;
                            voice_q    <= free_idx;
                            note_q     <= cur_entry.field_a;
                            duration_q <= cur_entry.field_b;
                            state_q    <= ST_ADVANCE;
                        end
                        // Otherwise stall here until a voice frees up and
                        // play is high; rom_addr stays put meanwhile.
                    end

                    // Only beats seen while already in WAIT are counted.
                    ST_WAIT: begin
                        if (play && beat) begin
                            wait_cnt_q <= wait_cnt_q - 1'b1;
                            if (wait_cnt_q == NOTE_W'(1)) state_q <= ST_ADVANCE;
                        end
                    end

                    ST_ADVANCE: begin
                        if (entry_q == '1) begin
                            // End of song: rewind and pause; PAUSED restarts
                            // on the next cycle if play is still high.
                            entry_q     <= '0;
                            song_done_q <= 1'b1;
                            state_q     <= ST_PAUSED;
                        end else begin
                            entry_q <= entry_q + 1'b1;
                            state_q <= play ? ST_FETCH : ST_PAUSED;
                        end
                    end

                    default: begin
                        state_q <= ST_PAUSED;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rom_addr  = {song_q, entry_q};
    assign new_note  = new_note_q;
    assign voice     = voice_q;
    assign note      = note_q;
    assign duration  = duration_q;
    assign song_done = song_done_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    // A note load and an end-of-song pulse come from different states.
    a_pulses_exclusive: assert property (
        @(posedge clk) disable iff (reset) !(new_note_q && song_done_q)
    );

    // A loaded voice index always names an existing note player.
    a_voice_in_range: assert property (
        @(posedge clk) disable iff (reset) new_note_q |-> (32'(voice_q) < NUM_VOICES)
    );

    // WAIT is only entered with a nonzero count and left when it hits zero.
    a_wait_count_live: assert property (
        @(posedge clk) disable iff (reset) (state_q == ST_WAIT) |-> (wait_cnt_q != '0)
    );

endmodule : song_reader

// File: tb/tb_song_reader.sv
// -----------------------------------------------------------------------------
// tb_song_reader
// Directed scenarios on a hand-written song 0, then randomized play / beat /
// busy traffic on a random song 1 checked cycle by cycle against an
// entry-walking reference model.
// -----------------------------------------------------------------------------
module tb_song_reader;

    logic        clk;
    logic        reset;
    logic        play;
    logic        new_song;
    logic [1:0]  song_sel;
    logic        beat;
    logic [2:0]  voice_busy;
    logic [6:0]  rom_addr;
    logic [11:0] rom_dout;
    logic        new_note;
    logic [1:0]  voice;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        song_done;

    song_reader dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .new_song   (new_song),
        .song_sel   (song_sel),
        .beat       (beat),
        .voice_busy (voice_busy),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .new_note   (new_note),
        .voice      (voice),
        .note       (note),
        .duration   (duration),
        .song_done  (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered song ROM: data valid one cycle after the address
    logic [11:0] rom_mem [128];
    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock; outputs are sampled and inputs changed 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        step();
        beat = 1'b0;
        step();
    endtask

    task automatic wait_addr(input string tag, input logic [6:0] target, input int budget);
        int n;
        n = 0;
        while (rom_addr !== target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(rom_addr), 32'(target));
    endtask

    task automatic wait_note(input string tag, input int budget);
        int n;
        n = 0;
        while (new_note !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(new_note), 32'd1);
    endtask

    // -------------------------------------------------------------------------
    // Reference model: walks entries as a sequential process. Each m_tick()
    // is one clock edge; the inputs seen are those held during the cycle that
    // edge closes. Expected outputs are those visible after the edge.
    // -------------------------------------------------------------------------
    logic        m_play, m_beat;
    logic [2:0]  m_busy;
    logic [1:0]  m_song;
    logic [4:0]  m_entry;
    logic        exp_new_note, exp_song_done;
    logic [1:0]  exp_voice;
    logic [5:0]  exp_note, exp_dur;
    logic [6:0]  exp_addr;

    task automatic m_tick();
        @(posedge clk);
        m_play        = play;
        m_beat        = beat;
        m_busy        = voice_busy;
        exp_new_note  = 1'b0;
        exp_song_done = 1'b0;
    endtask

    task automatic model_run();
        logic        resume;
        logic        placed;
        logic [11:0] w;
        int          cnt;
        int          lowest;
        resume = 1'b0;
        forever begin
            // Idle until an edge that sees play high (skipped when the
            // previous entry ended with play high).
            if (!resume) begin
                do m_tick(); while (!m_play);
            end
            m_tick();                       // address captured by the ROM
            w = rom_mem[{m_song, m_entry}];
            if (w[11]) begin
                cnt = int'(w[10:5]);
                m_tick();                   // count loaded; beats from here on
                while (cnt != 0) begin
                    m_tick();
                    if (m_play && m_beat) cnt--;
                end
            end else if (w[10:5] == 6'd0 || w[4:0] == 5'd0) begin
                m_tick();
            end else begin
                placed = 1'b0;
                while (!placed) begin
                    m_tick();
                    if (m_play && m_busy != 3'b111) begin
                        lowest = 2;
                        for (int i = 2; i >= 0; i--) if (!m_busy[i]) lowest = i;
                        exp_new_note = 1'b1;
                        exp_voice    = 2'(lowest);
                        exp_note     = w[10:5];
                        exp_dur      = {1'b0, w[4:0]};
                        placed       = 1'b1;
                    end
                end
            end
            m_tick();                       // move to the next entry
            if (m_entry == 5'd31) begin
                m_entry       = 5'd0;
                exp_song_done = 1'b1;
                resume        = 1'b0;
            end else begin
                m_entry = m_entry + 5'd1;
                resume  = m_play;
            end
            exp_addr = {m_song, m_entry};
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        // Song 0: hand-written; songs 1..3: random mix of entry kinds
        for (int a = 0; a < 128; a++) rom_mem[a] = 12'd0;
        rom_mem[0]  = {1'b0, 6'd49, 5'd12};
        rom_mem[1]  = {1'b0, 6'd5,  5'd3};
        rom_mem[2]  = {1'b0, 6'd7,  5'd9};
        rom_mem[3]  = {1'b1, 6'd12, 5'd0};
        rom_mem[4]  = {1'b1, 6'd12, 5'd7};   // low bits ignored on advance
        rom_mem[5]  = {1'b0, 6'd33, 5'd0};   // zero duration: no-op
        rom_mem[6]  = {1'b0, 6'd0,  5'd4};   // zero note: no-op
        rom_mem[31] = {1'b0, 6'd20, 5'd4};
        for (int a = 32; a < 128; a++) begin
            int k;
            k = int'($urandom_range(9));
            if (k < 5)      rom_mem[a] = {1'b0, 6'($urandom), 5'($urandom)};
            else if (k < 7) rom_mem[a] = {1'b1, 6'($urandom_range(5)), 5'($urandom)};
            else if (k < 8) rom_mem[a] = {1'b0, 6'($urandom), 5'd0};
            else            rom_mem[a] = {1'b0, 6'd0, 5'($urandom)};
        end

        reset      = 1'b1;
        play       = 1'b0;
        new_song   = 1'b0;
        song_sel   = 2'd0;
        beat       = 1'b0;
        voice_busy = 3'b000;

        // Reset state
        step();
        step();
        check("rst_addr",      32'(rom_addr),  32'd0);
        check("rst_new_note",  32'(new_note),  32'd0);
        check("rst_song_done", 32'(song_done), 32'd0);
        check("rst_voice",     32'(voice),     32'd0);
        check("rst_note",      32'(note),      32'd0);
        check("rst_duration",  32'(duration),  32'd0);
        reset = 1'b0;
        step();
        step();
        check("paused_addr", 32'(rom_addr), 32'd0);
        check("paused_note", 32'(new_note), 32'd0);

        // First note: play rises in cycle 0, load pulse in cycle 3
        play = 1'b1;
        step();
        step();
        check("lat_c2_no_note", 32'(new_note), 32'd0);
        step();
        check("lat_c3_new_note", 32'(new_note), 32'd1);
        check("lat_c3_voice",    32'(voice),    32'd0);
        check("lat_c3_note",     32'(note),     32'd49);
        check("lat_c3_duration", 32'(duration), 32'd12);
        voice_busy = 3'b111;
        step();
        check("lat_c4_addr",     32'(rom_addr), 32'd1);
        check("lat_c4_pulse",    32'(new_note), 32'd0);

        // All voices busy: stall in place; then voice 1 frees up
        step();
        step();
        check("stall_no_note", 32'(new_note), 32'd0);
        check("stall_addr",    32'(rom_addr), 32'd1);
        voice_busy = 3'b101;
        step();
        check("free1_new_note", 32'(new_note), 32'd1);
        check("free1_voice",    32'(voice),    32'd1);
        check("free1_note",     32'(note),     32'd5);
        check("free1_duration", 32'(duration), 32'd3);

        // Voices 0 and 1 busy: voice 2 is chosen
        voice_busy = 3'b011;
        step();
        step();
        step();
        check("free2_new_note", 32'(new_note), 32'd1);
        check("free2_voice",    32'(voice),    32'd2);
        check("free2_note",     32'(note),     32'd7);
        check("free2_duration", 32'(duration), 32'd9);
        voice_busy = 3'b000;

        // Advance of 12 beats; a beat during decode must not count
        step();
        check("adv_fetch_addr", 32'(rom_addr), 32'd3);
        step();
        beat = 1'b1;
        step();
        beat = 1'b0;
        for (int i = 0; i < 11; i++) pulse_beat();
        check("adv12_after11", 32'(rom_addr), 32'd3);
        pulse_beat();
        check("adv12_after12", 32'(rom_addr), 32'd4);

        // Advance of 12 beats with 5 beats ignored while paused
        step();
        step();
        for (int i = 0; i < 4; i++) pulse_beat();
        play = 1'b0;
        for (int i = 0; i < 5; i++) pulse_beat();
        play = 1'b1;
        for (int i = 0; i < 7; i++) pulse_beat();
        check("adv_pause_after16", 32'(rom_addr), 32'd4);
        pulse_beat();
        check("adv_pause_after17", 32'(rom_addr), 32'd5);

        // No-op entries skipped; last entry ends the song, which restarts
        wait_note("last_entry_note", 300);
        check("last_entry_value", 32'(note),     32'd20);
        check("last_entry_addr",  32'(rom_addr), 32'd31);
        step();
        check("song_done_pulse", 32'(song_done), 32'd1);
        check("song_done_addr",  32'(rom_addr),  32'd0);
        step();
        check("song_done_once",  32'(song_done), 32'd0);
        step();
        step();
        check("restart_new_note", 32'(new_note), 32'd1);
        check("restart_note",     32'(note),     32'd49);

        // new_song during WAIT, coincident with a beat
        wait_addr("ns_reach_adv", 7'd3, 60);
        step();
        step();
        new_song = 1'b1;
        song_sel = 2'd2;
        beat     = 1'b1;
        play     = 1'b0;
        step();
        new_song = 1'b0;
        beat     = 1'b0;
        check("ns_addr",      32'(rom_addr),  32'd64);
        check("ns_new_note",  32'(new_note),  32'd0);
        check("ns_song_done", 32'(song_done), 32'd0);
        step();
        step();
        step();
        check("ns_held_addr", 32'(rom_addr), 32'd64);
        check("ns_held_note", 32'(new_note), 32'd0);

        // Asynchronous reset between clock edges in the middle of a wait
        new_song = 1'b1;
        song_sel = 2'd0;
        play     = 1'b1;
        step();
        new_song = 1'b0;
        wait_addr("ar_reach_adv", 7'd3, 60);
        step();
        step();
        check("ar_pre_note", 32'(note), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check("ar_addr",     32'(rom_addr),  32'd0);
        check("ar_note",     32'(note),      32'd0);
        check("ar_duration", 32'(duration),  32'd0);
        check("ar_voice",    32'(voice),     32'd0);
        check("ar_new_note", 32'(new_note),  32'd0);
        check("ar_done",     32'(song_done), 32'd0);
        step();
        reset = 1'b0;

        // Randomized traffic on song 1 against the reference model
        play     = 1'b0;
        new_song = 1'b1;
        song_sel = 2'd1;
        step();
        new_song = 1'b0;
        check("rnd_start_addr", 32'(rom_addr), 32'd32);
        m_song        = 2'd1;
        m_entry       = 5'd0;
        exp_addr      = 7'd32;
        exp_new_note  = 1'b0;
        exp_song_done = 1'b0;
        exp_voice     = 2'd0;
        exp_note      = 6'd0;
        exp_dur       = 6'd0;
        fork
            model_run();
        join_none
        for (int c = 0; c < 4000; c++) begin
            play       = ($urandom_range(7) != 0);
            beat       = ($urandom_range(2) == 0);
            voice_busy = 3'($urandom);
            step();
            check("rnd_addr",      32'(rom_addr),  32'(exp_addr));
            check("rnd_new_note",  32'(new_note),  32'(exp_new_note));
            check("rnd_song_done", 32'(song_done), 32'(exp_song_done));
            check("rnd_voice",     32'(voice),     32'(exp_voice));
            check("rnd_note",      32'(note),      32'(exp_note));
            check("rnd_duration",  32'(duration),  32'(exp_dur));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_song_reader
